// File: rtl/cpu_step_pkg.sv
// Shared definitions for the CPU step/run clock-enable block:
// FSM state encoding and default parameter values.
package cpu_step_pkg;

    typedef enum logic [1:0] {
        ST_STEP   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10
    } step_state_t;

    localparam int DEBOUNCE_DEFAULT = 1_000_000;
    localparam int CNT_W_DEFAULT    = 16;

endpackage

// File: rtl/cpu_step_control_if.sv
// Board-side signal bundle of cpu_step_control.
// The master modport drives the raw inputs; the slave modport is the
// step controller. cycle_count exists only when STEP_COUNTER_EN is defined.
interface cpu_step_control_if #(
    parameter int CNT_W = 16
);
    logic SLOW_CLK;
    logic BTN_STEP;
    logic RUN;
    logic HALT;
    logic cpu_en;
    logic halted;
`ifdef STEP_COUNTER_EN
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output SLOW_CLK, BTN_STEP, RUN, HALT,
        input  cpu_en, halted, cycle_count
    );

    modport slave (
        input  SLOW_CLK, BTN_STEP, RUN, HALT,
        output cpu_en, halted, cycle_count
    );
`else
    modport master (
        output SLOW_CLK, BTN_STEP, RUN, HALT,
        input  cpu_en, halted
    );

    modport slave (
        input  SLOW_CLK, BTN_STEP, RUN, HALT,
        output cpu_en, halted
    );
`endif
endinterface

// File: rtl/cpu_step_control_debouncer.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and
// debounced level. The level follows the synchronized button only after
// DEBOUNCE_CYCLES consecutive cycles of disagreement; any agreeing cycle
// restarts the count. rise is a one-cycle pulse on the level's rising edge.
module debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic MCLK,
    input  logic RESET_IN,
    input  logic btn_raw,
    output logic level,
    output logic rise
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          btn_meta;
    logic          btn_sync;
    logic          level_q;
    logic          level_prev;
    logic [CW-1:0] cnt;

    // Synchronize the button, count stable disagreement, update level
    always_ff @(posedge MCLK or posedge RESET_IN) begin
        if (RESET_IN) begin
            btn_meta   <= 1'b0;
            btn_sync   <= 1'b0;
            level_q    <= 1'b0;
            level_prev <= 1'b0;
            cnt        <= '0;
        end else begin
            btn_meta   <= btn_raw;
            btn_sync   <= btn_meta;
            level_prev <= level_q;
            if (btn_sync == level_q) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level_q <= btn_sync;
                cnt     <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign level = level_q;
    assign rise  = level_q & ~level_prev;

endmodule

// File: rtl/cpu_step_control.sv
// cpu_step_control: turns the divider's slow square wave (free-run) or the
// debounced STEP button (single-step) into one-MCLK-cycle cpu_en pulses,
// and latches a CPU halt request until reset.
// Optional feature macro: STEP_COUNTER_EN adds the cycle_count output.
module cpu_step_control
    import cpu_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT
) (
    input  logic MCLK,
    input  logic RESET_IN,
    cpu_step_control_if.slave bus
);
    if (CNT_W < 1 || DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("cpu_step_control: CNT_W and DEBOUNCE_CYCLES must be >= 1");
    end

    logic        slow_meta;
    logic        slow_s1;
    logic        slow_s2;
    logic        slow_rise;
    logic        run_meta;
    logic        run_s;
    logic        step_rise;
    step_state_t state;
    logic        cpu_en_q;
    logic        halted_q;

    // Synchronize SLOW_CLK (plus one history stage) and the RUN switch
    always_ff @(posedge MCLK or posedge RESET_IN) begin
        if (RESET_IN) begin
            slow_meta <= 1'b0;
            slow_s1   <= 1'b0;
            slow_s2   <= 1'b0;
            run_meta  <= 1'b0;
            run_s     <= 1'b0;
        end else begin
            slow_meta <= bus.SLOW_CLK;
            slow_s1   <= slow_meta;
            slow_s2   <= slow_s1;
            run_meta  <= bus.RUN;
            run_s     <= run_meta;
        end
    end

    assign slow_rise = slow_s1 & ~slow_s2;

    debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .MCLK    (MCLK),
        .RESET_IN(RESET_IN),
        .btn_raw (bus.BTN_STEP),
        .level   (),
        .rise    (step_rise)
    );

    // Mode FSM; the pulse source is chosen by the current state, so a mode
    // change and an edge in the same cycle act under the old mode. HALT wins.
    always_ff @(posedge MCLK or posedge RESET_IN) begin
        if (RESET_IN) begin
            state    <= ST_STEP;
            cpu_en_q <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state)
                ST_STEP: begin
                    if (bus.HALT) begin
                        state    <= ST_HALTED;
                        cpu_en_q <= 1'b0;
                        halted_q <= 1'b1;
                    end else begin
                        cpu_en_q <= step_rise;
                        halted_q <= 1'b0;
                        if (run_s) state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.HALT) begin
                        state    <= ST_HALTED;
                        cpu_en_q <= 1'b0;
                        halted_q <= 1'b1;
                    end else begin
                        cpu_en_q <= slow_rise;
                        halted_q <= 1'b0;
                        if (!run_s) state <= ST_STEP;
                    end
                end
                ST_HALTED: begin
                    cpu_en_q <= 1'b0;
                    halted_q <= 1'b1;
                end
                default: begin
                    state    <= ST_STEP;
                    cpu_en_q <= 1'b0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cpu_en = cpu_en_q;
    assign bus.halted = halted_q;

`ifdef STEP_COUNTER_EN
    logic [CNT_W-1:0] count_q;

    // Count issued cpu_en pulses, wrapping naturally
    always_ff @(posedge MCLK or posedge RESET_IN) begin
        if (RESET_IN) begin
            count_q <= '0;
        end else if (cpu_en_q) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign bus.cycle_count = count_q;
`endif

endmodule
